// File: rtl/bmp_stream_parser.sv
//==============================================================================
// Module      : bmp_stream_parser
// Description : Parses a 24-bit uncompressed BMP byte stream and emits
//               framebuffer pixel writes (bottom-up rows mapped to top-down y).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bmp_stream_parser #(
  parameter int H_MAX      = 640,
  parameter int V_MAX      = 480,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  pix_valid,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  output logic [23:0]           pix_data,
  output logic                  hdr_ok,
  output logic [11:0]           img_width,
  output logic [11:0]           img_height,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_code
);

  localparam logic [31:0]           c_h_max   = 32'(H_MAX);
  localparam logic [31:0]           c_v_max   = 32'(V_MAX);
  localparam logic [ADDR_WIDTH-1:0] c_h_max_a = ADDR_WIDTH'(H_MAX);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_SKIP = 3'd1,
    S_PIX  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]           r_idx;
  logic [15:0]           r_sig;
  logic [31:0]           r_offset;
  logic [31:0]           r_width32;
  logic [31:0]           r_height32;
  logic [15:0]           r_bpp;
  logic [31:0]           r_comp;
  logic [1:0]            r_phase;
  logic [1:0]            r_pad;
  logic [11:0]           r_x;
  logic [11:0]           r_y;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [7:0]            r_b;
  logic [7:0]            r_g;

  logic [2:0]            w_chk_code;
  logic                  w_hdr_end;
  logic                  w_skip_end;
  logic                  w_pix_byte;
  logic                  w_pix_r;
  logic                  w_row_end;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_base_init;

  // Header checks in priority order; 0 means the header is acceptable.
  always_comb begin
    w_chk_code = 3'd0;
    if (r_sig != 16'h4D42)
      w_chk_code = 3'd1;
    else if (r_bpp != 16'd24)
      w_chk_code = 3'd2;
    else if (r_comp != 32'd0)
      w_chk_code = 3'd3;
    else if (r_width32 == 32'd0 || r_width32 > c_h_max ||
             r_height32 == 32'd0 || r_height32[31] || r_height32 > c_v_max)
      w_chk_code = 3'd4;
    else if (r_offset < 32'd54)
      w_chk_code = 3'd5;
  end

  assign w_hdr_end   = in_valid && (r_state == S_HDR) && (r_idx == 32'd53);
  assign w_skip_end  = in_valid && (r_state == S_SKIP) && (r_idx == r_offset - 32'd1);
  assign w_pix_byte  = in_valid && (r_state == S_PIX) && (r_pad == 2'd0);
  assign w_pix_r     = w_pix_byte && (r_phase == 2'd2);
  assign w_row_end   = (r_x == img_width - 12'd1);
  assign w_last      = w_row_end && (r_y == 12'd0);
  assign w_base_init = ADDR_WIDTH'(r_height32[11:0] - 12'd1) * c_h_max_a;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_state <= S_HDR;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR: begin
        if (w_hdr_end) begin
          if (w_chk_code != 3'd0)
            w_next = S_ERR;
          else if (r_offset == 32'd54)
            w_next = S_PIX;
          else
            w_next = S_SKIP;
        end
      end
      S_SKIP:  if (w_skip_end) w_next = S_PIX;
      S_PIX:   if (w_pix_r && w_last) w_next = S_DONE;
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx      <= 32'd0;
      r_sig      <= 16'd0;
      r_offset   <= 32'd0;
      r_width32  <= 32'd0;
      r_height32 <= 32'd0;
      r_bpp      <= 16'd0;
      r_comp     <= 32'd0;
      r_phase    <= 2'd0;
      r_pad      <= 2'd0;
      r_x        <= 12'd0;
      r_y        <= 12'd0;
      r_row_base <= '0;
      r_b        <= 8'd0;
      r_g        <= 8'd0;
      pix_valid  <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= 24'd0;
      hdr_ok     <= 1'b0;
      img_width  <= 12'd0;
      img_height <= 12'd0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 3'd0;
    end else begin
      pix_valid <= 1'b0;

      if (in_valid && r_idx != 32'hFFFF_FFFF)
        r_idx <= r_idx + 32'd1;

      // Little-endian fields shift in from the top so the first byte ends lowest.
      if (in_valid && r_state == S_HDR) begin
        if (r_idx <= 32'd1)
          r_sig <= {in_byte, r_sig[15:8]};
        if (r_idx >= 32'd10 && r_idx <= 32'd13)
          r_offset <= {in_byte, r_offset[31:8]};
        if (r_idx >= 32'd18 && r_idx <= 32'd21)
          r_width32 <= {in_byte, r_width32[31:8]};
        if (r_idx >= 32'd22 && r_idx <= 32'd25)
          r_height32 <= {in_byte, r_height32[31:8]};
        if (r_idx >= 32'd28 && r_idx <= 32'd29)
          r_bpp <= {in_byte, r_bpp[15:8]};
        if (r_idx >= 32'd30 && r_idx <= 32'd33)
          r_comp <= {in_byte, r_comp[31:8]};
      end

      if (w_hdr_end) begin
        if (w_chk_code != 3'd0) begin
          error    <= 1'b1;
          err_code <= w_chk_code;
        end else begin
          hdr_ok     <= 1'b1;
          img_width  <= r_width32[11:0];
          img_height <= r_height32[11:0];
          r_x        <= 12'd0;
          r_y        <= r_height32[11:0] - 12'd1;
          r_row_base <= w_base_init;
          r_phase    <= 2'd0;
          r_pad      <= 2'd0;
        end
      end

      if (in_valid && r_state == S_PIX) begin
        if (r_pad != 2'd0) begin
          r_pad <= r_pad - 2'd1;
        end else begin
          case (r_phase)
            2'd0: begin
              r_b     <= in_byte;
              r_phase <= 2'd1;
            end
            2'd1: begin
              r_g     <= in_byte;
              r_phase <= 2'd2;
            end
            default: begin
              pix_valid <= 1'b1;
              pix_addr  <= r_row_base + ADDR_WIDTH'(r_x);
              pix_data  <= {in_byte, r_g, r_b};
              r_phase   <= 2'd0;
              if (w_row_end) begin
                if (r_y == 12'd0) begin
                  done <= 1'b1;
                end else begin
                  // Rows are stored bottom-up; padding count equals width mod 4.
                  r_x        <= 12'd0;
                  r_y        <= r_y - 12'd1;
                  r_row_base <= r_row_base - c_h_max_a;
                  r_pad      <= img_width[1:0];
                end
              end else begin
                r_x <= r_x + 12'd1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bmp_stream_parser.sv
//==============================================================================
// Module      : tb_bmp_stream_parser
// Description : Directed scoreboard bench for bmp_stream_parser.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bmp_stream_parser;

  localparam int c_aw = 19;

  logic            clk;
  logic            rstn;
  logic            in_valid;
  logic [7:0]      in_byte;
  logic            pix_valid;
  logic [c_aw-1:0] pix_addr;
  logic [23:0]     pix_data;
  logic            hdr_ok;
  logic [11:0]     img_width;
  logic [11:0]     img_height;
  logic            done;
  logic            error;
  logic [2:0]      err_code;

  int checks = 0;
  int errors = 0;

  logic [7:0]         file_q[$];
  logic [c_aw+23:0]   sb[$];

  bmp_stream_parser #(.H_MAX(640), .V_MAX(480), .ADDR_WIDTH(c_aw)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .pix_valid (pix_valid),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .hdr_ok    (hdr_ok),
    .img_width (img_width),
    .img_height(img_height),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every strobe must match the oldest expected pixel.
  always begin
    logic [c_aw+23:0] e;
    @(posedge clk);
    #1;
    if (rstn && pix_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_pix", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pix_addr", 32'(pix_addr), 32'(e[c_aw+23:24]));
        chk("pix_data", 32'(pix_data), 32'(e[23:0]));
      end
    end
  end

  task automatic put_le(input int unsigned v, input int n);
    for (int i = 0; i < n; i++) file_q.push_back(8'((v >> (8 * i)) & 32'hFF));
  endtask

  task automatic build(input logic [7:0] sig0, input int w, input int h, input int off,
                       input int bpp, input int comp, input bit gen_pix);
    int k;
    int pad;
    logic [7:0] bb, gg, rr;
    file_q.delete();
    file_q.push_back(sig0);
    file_q.push_back(8'h4D);
    put_le(0, 8);
    put_le(off, 4);
    put_le(40, 4);
    put_le(w, 4);
    put_le(h, 4);
    put_le(1, 2);
    put_le(bpp, 2);
    put_le(comp, 4);
    put_le(0, 20);
    for (int j = 54; j < off; j++) file_q.push_back(8'hEE);
    if (gen_pix) begin
      k = 0;
      pad = (4 - ((3 * w) % 4)) % 4;
      for (int r = 0; r < h; r++) begin
        for (int x = 0; x < w; x++) begin
          bb = 8'(3 * k + 1);
          gg = 8'(3 * k + 2);
          rr = 8'(3 * k + 3);
          file_q.push_back(bb);
          file_q.push_back(gg);
          file_q.push_back(rr);
          sb.push_back({c_aw'((h - 1 - r) * 640 + x), rr, gg, bb});
          k++;
        end
        for (int p = 0; p < pad; p++) file_q.push_back(8'h00);
      end
    end else begin
      put_le(32'h5A5A5A5A, 4);
    end
  endtask

  task automatic send(input bit gapped, input int limit);
    int n;
    for (int i = 0; i < file_q.size() && i < limit; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = file_q[i];
      if (gapped) begin
        n = int'($urandom_range(1, 5));
        repeat (n) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_addr"},  32'(pix_addr),  32'd0);
    chk({tag, "_pix_data"},  32'(pix_data),  32'd0);
    chk({tag, "_hdr_ok"},    32'(hdr_ok),    32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_error"},     32'(error),     32'd0);
    chk({tag, "_err_code"},  32'(err_code),  32'd0);
    chk({tag, "_width"},     32'(img_width), 32'd0);
    chk({tag, "_height"},    32'(img_height),32'd0);
  endtask

  task automatic check_ok(input string tag, input int w, input int h);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_done"},     32'(done),      32'd1);
    chk({tag, "_hdr_ok"},   32'(hdr_ok),    32'd1);
    chk({tag, "_error"},    32'(error),     32'd0);
    chk({tag, "_width"},    32'(img_width), 32'(w));
    chk({tag, "_height"},   32'(img_height),32'(h));
  endtask

  task automatic check_err(input string tag, input int code);
    chk({tag, "_error"},    32'(error),    32'd1);
    chk({tag, "_err_code"}, 32'(err_code), 32'(code));
    chk({tag, "_hdr_ok"},   32'(hdr_ok),   32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
  endtask

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // 2x2 back-to-back, offset 54
    build(8'h42, 2, 2, 54, 24, 0, 1'b1);
    send(1'b0, 1 << 30);
    check_ok("b2b2x2", 2, 2);

    // 1x1 with 4 junk bytes before pixel data
    do_reset();
    build(8'h42, 1, 1, 58, 24, 0, 1'b1);
    send(1'b0, 1 << 30);
    check_ok("skip1x1", 1, 1);

    do_reset();
    build(8'h41, 2, 2, 54, 24, 0, 1'b0);
    send(1'b0, 1 << 30);
    check_err("badsig", 1);

    do_reset();
    build(8'h42, 2, 2, 54, 32, 0, 1'b0);
    send(1'b0, 1 << 30);
    check_err("bpp32", 2);

    do_reset();
    build(8'h42, 641, 2, 54, 24, 0, 1'b0);
    send(1'b0, 1 << 30);
    check_err("width641", 4);

    // Same 2x2 file with random idle gaps
    do_reset();
    build(8'h42, 2, 2, 54, 24, 0, 1'b1);
    send(1'b1, 1 << 30);
    check_ok("gap2x2", 2, 2);

    // Reset after the 2nd pixel, with in_valid active during reset
    do_reset();
    build(8'h42, 2, 2, 54, 24, 0, 1'b1);
    send(1'b0, 60);
    chk("mid_sb_left", 32'(sb.size()), 32'd2);
    chk("mid_done", 32'(done), 32'd0);
    #3;
    rstn     = 1'b0;
    in_valid = 1'b1;
    in_byte  = 8'h42;
    #1;
    check_zero("async_rst");
    repeat (3) @(negedge clk);
    check_zero("in_rst");
    sb.delete();
    in_valid = 1'b0;
    rstn     = 1'b1;
    @(negedge clk);
    build(8'h42, 2, 2, 54, 24, 0, 1'b1);
    send(1'b0, 1 << 30);
    check_ok("post_rst", 2, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bmp_stream_parser.md
BMP_STREAM_PARSER -- requirements
Module: bmp_stream_parser

Interface
REQ-001 SHALL have parameter H_MAX, default 640: maximum accepted image width, and the framebuffer row stride.
REQ-002 SHALL have parameter V_MAX, default 480: maximum accepted image height.
REQ-003 SHALL have parameter ADDR_WIDTH, default 19: width of the pixel address.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk  input  1  sole clock, all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  one file byte present this cycle (sd_file_reader outen); no backpressure.
- in_byte  input  8  file byte (sd_file_reader outbyte).
- pix_valid  output  1  one-cycle strobe: pix_addr/pix_data valid.
- pix_addr  output  ADDR_WIDTH  framebuffer address, y*H_MAX+x.
- pix_data  output  24  {R,G,B}.
- hdr_ok  output  1  header accepted; held until reset.
- img_width  output  12  parsed width, valid while hdr_ok.
- img_height  output  12  parsed height, valid while hdr_ok.
- done  output  1  all pixels emitted; held until reset.
- error  output  1  header rejected; held until reset.
- err_code  output  3  cause, valid while error.

Function
REQ-005 SHALL implement states HDR, SKIP, PIX, DONE, ERR, and SHALL advance only on cycles with in_valid=1.
REQ-006 SHALL keep a byte index counting accepted bytes from 0 and SHALL capture these little-endian header fields:
- signature: bytes 0-1.
- data offset: bytes 10-13.
- width: bytes 18-21.
- height: bytes 22-25.
- bpp: bytes 28-29.
- compression: bytes 30-33.
REQ-007 SHALL, on acceptance of byte 53, evaluate the checks in this priority order and enter ERR with the corresponding err_code:
- signature != 0x42,0x4D: code 1.
- bpp != 24: code 2.
- compression != 0: code 3.
- width 0 or > H_MAX, or height 0, > V_MAX, or negative (bit 31 set): code 4.
- offset < 54: code 5.
REQ-008 SHALL, when all checks in REQ-007 pass, set hdr_ok and enter PIX if offset == 54, otherwise enter SKIP.
REQ-009 SHALL, in SKIP, discard bytes until byte index offset-1 is accepted, then enter PIX.
REQ-010 SHALL, in PIX, assemble three bytes per pixel in file order B, G, R.
REQ-011 SHALL assert pix_valid the cycle after the R byte is accepted (latency 1), with pix_data={R,G,B}.
REQ-012 SHALL emit rows bottom-up: the first file row maps to y=img_height-1, and y decrements per row; x counts 0..width-1 within each row.
REQ-013 SHALL compute pix_addr as row_base + x, where row_base is initialised to (img_height-1)*H_MAX and reduced by H_MAX at each row end.
REQ-014 SHALL, after the last pixel of each row, discard width[1:0] padding bytes (0-3) before the next row's B byte.
REQ-015 SHALL enter DONE on acceptance of the R byte of the last pixel (x=width-1, y=0), set done in that same update, and ignore the trailing padding bytes and all later bytes.
REQ-016 SHALL ignore all bytes in DONE and ERR, with pix_valid held at 0.
REQ-017 SHALL generate back-to-back pixels on consecutive in_valid cycles with no lost bytes.
REQ-018 SHALL use pixel and row counters 12 bits wide, and the byte index 32 bits wide, saturating at its maximum.

Reset
REQ-019 SHALL, on rstn=0, asynchronously force the following:
- state to HDR.
- byte index, phase, x, y and row_base to 0.
- pix_valid, pix_addr and pix_data to 0.
- hdr_ok, done and error to 0.
- err_code, img_width and img_height to 0.
REQ-020 SHALL, on reset mid-stream, restart parsing so that the next accepted byte is treated as file byte 0.
REQ-021 SHALL treat rstn deassertion as synchronous to clk; in_valid during reset SHALL be ignored.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- 2x2 image, offset 54, pixels 01 02 03 | 04 05 06 | pad 00 00 | 07 08 09 | 0A 0B 0C -> pix_valid x4: addr 640/0x030201, 641/0x060504, 0/0x090807, 1/0x0C0B0A; done after 4th pixel; hdr_ok=1.
- Offset 58 with 4 junk bytes, 1x1 image -> junk skipped; single pixel at addr 0; done.
- Byte 0 = 0x41 -> error=1, err_code=1 after byte 53; no pix_valid.
- bpp=32 -> err_code=2; width=641 -> err_code=4.
- in_valid gapped randomly (1-5 idle cycles) on the 2x2 case -> identical pixel sequence to the back-to-back run.
- rstn pulsed low after the 2nd pixel, then a full 2x2 file resent -> all outputs 0 during reset; correct 4 pixels afterwards.
